// File: rtl/datapath_seq.sv
// datapath_seq: multicycle control sequencer for a RISC-V style datapath.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. It handshakes with
// the instruction and data memories, and a bounded wait counter sends it to a
// sticky TRAP state when a memory stalls too long.
//
// Parameters:
//   MEM_TIMEOUT  wait cycles allowed on one memory handshake before trapping (1..255)
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   Instr[31:0]             instruction register contents (only [6:0] decoded)
//   Zero                    branch condition, sampled in EXEC
//   imem_req / imem_ready   instruction fetch handshake
//   dmem_req / dmem_we / dmem_ready   data memory handshake
//   IRWrite, PCWrite, RegWrite, PCSrc, ResultSrc[1:0]   datapath controls
//   trap                    sticky fault flag
//   state_o[2:0]            current state encoding (debug)
//   retired, stall_cycles   performance counters, present only when
//                           DATAPATH_SEQ_PERF_EN is defined
module datapath_seq #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic [1:0]  ResultSrc,
  output logic        trap,
  output logic [2:0]  state_o
`ifdef DATAPATH_SEQ_PERF_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] stall_cycles
`endif
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opcode_q;
  logic             armed;

  logic             is_load, is_store, is_branch, is_jump;
  logic [CNT_W-1:0] wait_inc;
  logic             timeout_hit;
  logic             instr_unused;

  // Upper instruction bits belong to the datapath, not the sequencer.
  assign instr_unused = ^Instr[31:7];

  function automatic logic legal_op(input logic [6:0] op);
    case (op)
      OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal_op = 1'b1;
      default:                           legal_op = 1'b0;
    endcase
  endfunction

  // Instruction class from the opcode captured in DECODE.
  assign is_load   = (opcode_q == OP_LOAD);
  assign is_store  = (opcode_q == OP_STORE);
  assign is_branch = (opcode_q == OP_BRANCH);
  assign is_jump   = (opcode_q == OP_JAL) || (opcode_q == OP_JALR);

  // Saturating increment; the trap decision looks at the count this wait
  // cycle would produce, so a ready in that same cycle still wins.
  assign wait_inc    = (wait_cnt == {CNT_W{1'b1}}) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign timeout_hit = (32'(wait_inc) >= MEM_TIMEOUT);

  // State, wait counter and opcode latch. armed keeps imem_req low until the
  // first clock edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      opcode_q <= '0;
      armed    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_FETCH: begin
          if (imem_req) begin
            if (imem_ready) begin
              state    <= S_DECODE;
              wait_cnt <= '0;
            end else if (timeout_hit) begin
              state    <= S_TRAP;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
        end
        S_DECODE: begin
          opcode_q <= Instr[6:0];
          wait_cnt <= '0;
          state    <= legal_op(Instr[6:0]) ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_load || is_store) begin
            state <= S_MEM;
          end else if (is_branch) begin
            state <= S_FETCH;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state    <= is_load ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (timeout_hit) begin
            state    <= S_TRAP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_inc;
          end
        end
        S_WB: begin
          state    <= S_FETCH;
          wait_cnt <= '0;
        end
        S_TRAP: begin
          wait_cnt <= '0;
        end
        default: begin
          state    <= S_TRAP;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Control decode from the state register plus the in-state handshake terms.
  always_comb begin
    imem_req  = 1'b0;
    IRWrite   = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    PCSrc     = 1'b0;
    ResultSrc = 2'b00;

    imem_req = armed && (state == S_FETCH);
    IRWrite  = imem_req && imem_ready;
    dmem_req = (state == S_MEM);
    dmem_we  = dmem_req && is_store;

    case (state)
      S_EXEC: begin
        if (is_branch) begin
          PCWrite = 1'b1;
          PCSrc   = Zero;
        end
      end
      S_MEM: begin
        if (is_store && dmem_ready) begin
          PCWrite = 1'b1;
        end
      end
      S_WB: begin
        RegWrite  = 1'b1;
        PCWrite   = 1'b1;
        PCSrc     = is_jump;
        ResultSrc = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
      end
      default: begin
      end
    endcase
  end

  assign trap    = (state == S_TRAP);
  assign state_o = state;

`ifdef DATAPATH_SEQ_PERF_EN
  logic stalled;

  assign stalled = (imem_req && !imem_ready) || (dmem_req && !dmem_ready);

  // Free-running counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      retired      <= retired + 32'(PCWrite);
      stall_cycles <= stall_cycles + 32'(stalled);
    end
  end
`endif

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq (MEM_TIMEOUT = 4). Each cycle's inputs
// and expected outputs come from a vector record; expected outputs go through
// a scoreboard queue and are compared mid-cycle on the falling edge.
module tb_datapath_seq;

  localparam int unsigned TO = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_X    = 7'b1111111;

  localparam logic [2:0] FE = 3'd0, DE = 3'd1, EX = 3'd2, ME = 3'd3, WB = 3'd4, TR = 3'd7;

  logic        clk, rst_n;
  logic [31:0] Instr;
  logic        Zero, imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
  logic        IRWrite, PCWrite, RegWrite, PCSrc, trap;
  logic [1:0]  ResultSrc;
  logic [2:0]  state_o;
`ifdef DATAPATH_SEQ_PERF_EN
  logic [31:0] retired, stall_cycles;
`endif

  datapath_seq #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .PCSrc(PCSrc),
    .ResultSrc(ResultSrc), .trap(trap), .state_o(state_o)
`ifdef DATAPATH_SEQ_PERF_EN
    , .retired(retired), .stall_cycles(stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [2:0] st;
    logic       ireq, irw, pcw, rw, pcsrc;
    logic [1:0] rs;
    logic       dreq, dwe, trp;
  } exp_t;

  typedef struct {
    string      tag;
    logic [6:0] op;
    logic       ir, dr, z;
    exp_t       e;
  } vec_t;

  vec_t        tbl[$];
  exp_t        sb_q[$];
  string       tag_q[$];
  int          n_cmp, n_err;
  int unsigned m_ret, m_stall;

  function automatic exp_t E(logic [2:0] st, logic ireq, logic irw, logic pcw, logic rw,
                             logic pcsrc, logic [1:0] rs, logic dreq, logic dwe, logic trp);
    exp_t e;
    e.st = st; e.ireq = ireq; e.irw = irw; e.pcw = pcw; e.rw = rw;
    e.pcsrc = pcsrc; e.rs = rs; e.dreq = dreq; e.dwe = dwe; e.trp = trp;
    return e;
  endfunction

  // Quiet state: no enables, no requests.
  function automatic exp_t Q(logic [2:0] st);
    return E(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, st == TR);
  endfunction

  function automatic vec_t V(string tag, logic [6:0] op, logic ir, logic dr, logic z, exp_t e);
    vec_t v;
    v.tag = tag; v.op = op; v.ir = ir; v.dr = dr; v.z = z; v.e = e;
    return v;
  endfunction

  function automatic exp_t sample();
    exp_t a;
    a = {state_o, imem_req, IRWrite, PCWrite, RegWrite, PCSrc, ResultSrc, dmem_req, dmem_we, trap};
    return a;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, compare on the falling edge, and
  // advance the counter model by what the expected outputs imply.
  task automatic step(vec_t v);
    exp_t        want;
    string       t;
    logic [13:0] av, wv;
    Instr      = {25'h155AA5, v.op};
    imem_ready = v.ir;
    dmem_ready = v.dr;
    Zero       = v.z;
    sb_q.push_back(v.e);
    tag_q.push_back(v.tag);
    @(negedge clk);
    want = sb_q.pop_front();
    t    = tag_q.pop_front();
    av   = sample();
    wv   = want;
    check(t, 32'(av), 32'(wv));
    if (want.pcw) m_ret++;
    if ((want.ireq && !v.ir) || (want.dreq && !v.dr)) m_stall++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_perf(string where);
`ifdef DATAPATH_SEQ_PERF_EN
    check({where, "_retired"}, retired, m_ret);
    check({where, "_stall_cycles"}, stall_cycles, m_stall);
`else
    if (where.len() == 0) $display("perf counters not built");
`endif
  endtask

  // Reset across two edges, then one un-armed cycle after release.
  task automatic reset_pulse(string tag);
    rst_n   = 1'b0;
    m_ret   = 0;
    m_stall = 0;
    step(V({tag, "_hold0"}, OP_X, 1'b1, 1'b1, 1'b1, Q(FE)));
    step(V({tag, "_hold1"}, OP_X, 1'b1, 1'b1, 1'b1, Q(FE)));
    rst_n = 1'b1;
    step(V({tag, "_rel"}, OP_X, 1'b1, 1'b1, 1'b1, Q(FE)));
  endtask

  localparam exp_t F_ACC  = 14'b000_1_1_0_0_0_00_0_0_0;
  localparam exp_t F_WAIT = 14'b000_1_0_0_0_0_00_0_0_0;

  initial begin
    n_cmp = 0; n_err = 0; m_ret = 0; m_stall = 0;
    rst_n = 1'b0; Instr = '0; Zero = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse("reset");
    check_perf("after_reset");

    // R-type, ready every cycle
    tbl.push_back(V("r_fetch",  OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("r_decode", OP_R, 1, 0, 0, Q(DE)));
    tbl.push_back(V("r_exec",   OP_X, 1, 1, 0, Q(EX)));
    tbl.push_back(V("r_wb",     OP_X, 1, 1, 1, E(WB, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0)));
    // Load: one fetch stall, then dmem_ready three cycles late
    tbl.push_back(V("ld_fwait", OP_X, 0, 0, 0, F_WAIT));
    tbl.push_back(V("ld_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("ld_dec",   OP_LD, 1, 0, 0, Q(DE)));
    tbl.push_back(V("ld_exec",  OP_X, 1, 1, 0, Q(EX)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V($sformatf("ld_mwait%0d", i), OP_X, 0, 0, 0, E(ME, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0)));
    tbl.push_back(V("ld_mrdy",  OP_X, 1, 1, 0, E(ME, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0)));
    tbl.push_back(V("ld_wb",    OP_X, 1, 1, 0, E(WB, 0, 0, 1, 1, 0, 2'b01, 0, 0, 0)));
    // Branch taken, then not taken
    tbl.push_back(V("bt_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("bt_dec",   OP_BR, 1, 0, 0, Q(DE)));
    tbl.push_back(V("bt_exec",  OP_X, 1, 1, 1, E(EX, 0, 0, 1, 0, 1, 2'b00, 0, 0, 0)));
    tbl.push_back(V("bn_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("bn_dec",   OP_BR, 1, 0, 0, Q(DE)));
    tbl.push_back(V("bn_exec",  OP_X, 1, 1, 0, E(EX, 0, 0, 1, 0, 0, 2'b00, 0, 0, 0)));
    // JAL, JALR, LUI
    tbl.push_back(V("jal_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("jal_dec",   OP_JAL, 1, 0, 0, Q(DE)));
    tbl.push_back(V("jal_exec",  OP_X, 1, 1, 0, Q(EX)));
    tbl.push_back(V("jal_wb",    OP_X, 1, 1, 0, E(WB, 0, 0, 1, 1, 1, 2'b10, 0, 0, 0)));
    tbl.push_back(V("jalr_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("jalr_dec",   OP_JALR, 1, 0, 0, Q(DE)));
    tbl.push_back(V("jalr_exec",  OP_X, 1, 1, 1, Q(EX)));
    tbl.push_back(V("jalr_wb",    OP_X, 1, 1, 0, E(WB, 0, 0, 1, 1, 1, 2'b10, 0, 0, 0)));
    tbl.push_back(V("lui_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("lui_dec",   OP_LUI, 1, 0, 0, Q(DE)));
    tbl.push_back(V("lui_exec",  OP_X, 1, 1, 1, Q(EX)));
    tbl.push_back(V("lui_wb",    OP_X, 1, 1, 1, E(WB, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0)));
    // Store: ready on the 4th wait cycle is accepted
    tbl.push_back(V("st_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("st_dec",   OP_ST, 1, 0, 0, Q(DE)));
    tbl.push_back(V("st_exec",  OP_X, 1, 1, 0, Q(EX)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(V($sformatf("st_mwait%0d", i), OP_X, 1, 0, 0, E(ME, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0)));
    tbl.push_back(V("st_mrdy4", OP_X, 1, 1, 0, E(ME, 0, 0, 1, 0, 0, 2'b00, 1, 1, 0)));
    // Store: ready never comes, trap after 4 wait cycles
    tbl.push_back(V("sto_fetch", OP_X, 1, 0, 0, F_ACC));
    tbl.push_back(V("sto_dec",   OP_ST, 1, 0, 0, Q(DE)));
    tbl.push_back(V("sto_exec",  OP_X, 1, 1, 0, Q(EX)));
    for (int i = 0; i < 4; i++)
      tbl.push_back(V($sformatf("sto_mwait%0d", i), OP_X, 1, 0, 0, E(ME, 0, 0, 0, 0, 0, 2'b00, 1, 1, 0)));
    tbl.push_back(V("sto_trap", OP_R, 1, 1, 1, Q(TR)));

    foreach (tbl[i]) step(tbl[i]);
    check_perf("table");

    for (int i = 0; i < 19; i++) step(V("sto_trap_hold", OP_R, 1, 1, 1, Q(TR)));
    reset_pulse("rst_after_sto");
    step(V("rst_after_sto_fetch", OP_X, 1, 0, 0, F_ACC));

    // Illegal opcode traps straight from DECODE and stays there
    step(V("ill_dec", OP_X, 1, 1, 1, Q(DE)));
    for (int i = 0; i < 20; i++) step(V($sformatf("ill_trap%0d", i), OP_R, 1, 1, 1, Q(TR)));
    reset_pulse("rst_after_ill");

    // Fetch handshake times out the same way
    for (int i = 0; i < 4; i++) step(V($sformatf("f_wait%0d", i), OP_X, 0, 1, 0, F_WAIT));
    step(V("f_trap", OP_X, 1, 1, 0, Q(TR)));
    reset_pulse("rst_after_ftrap");

    // Reset asserted mid data handshake drops dmem_req without a clock edge
    step(V("mr_fetch", OP_X, 1, 0, 0, F_ACC));
    step(V("mr_dec",   OP_LD, 1, 0, 0, Q(DE)));
    step(V("mr_exec",  OP_X, 1, 0, 0, Q(EX)));
    step(V("mr_mwait", OP_X, 1, 0, 0, E(ME, 0, 0, 0, 0, 0, 2'b00, 1, 0, 0)));
    #2;
    rst_n = 1'b0;
    m_ret = 0;
    m_stall = 0;
    #1;
    check("mr_async_dmem_req", 32'(dmem_req), 32'd0);
    check("mr_async_state", 32'(state_o), 32'(FE));
    check("mr_async_imem_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    step(V("mr_hold", OP_X, 1, 1, 1, Q(FE)));
    rst_n = 1'b1;
    step(V("mr_rel", OP_X, 1, 1, 1, Q(FE)));
    step(V("mr_first_fetch", OP_X, 0, 0, 0, F_WAIT));
    check_perf("mr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
